// File: rtl/controle_multiciclo_pkg.sv
// Shared state codes, opcodes and datapath select encodings for the multicycle MIPS control unit.
package controle_pkg;

    localparam int unsigned OP_W = 6;

    typedef enum logic [5:0] {
        RESET        = 6'd0,
        BUSCA        = 6'd1,
        BUSCA_ESPERA = 6'd2,
        BUSCA_IR     = 6'd3,
        DECODE       = 6'd4,
        MEM_ENDERECO = 6'd5,
        LW_LEITURA   = 6'd6,
        LW_ESPERA    = 6'd7,
        LW_MDR       = 6'd8,
        LW_ESCRITA   = 6'd9,
        SW_ESCRITA   = 6'd10,
        R_EXEC       = 6'd11,
        R_ESCRITA    = 6'd12,
        ADDI_EXEC    = 6'd13,
        ADDI_ESCRITA = 6'd14,
        BEQ          = 6'd15,
        BNE          = 6'd16,
        JUMP         = 6'd17,
        INVALIDO     = 6'd18
    } estado_t;

    localparam logic [OP_W-1:0] OP_R    = 6'h00;
    localparam logic [OP_W-1:0] OP_LW   = 6'h23;
    localparam logic [OP_W-1:0] OP_SW   = 6'h2B;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE  = 6'h05;
    localparam logic [OP_W-1:0] OP_J    = 6'h02;
    localparam logic [OP_W-1:0] OP_ADDI = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;

    localparam logic [1:0] B_REG      = 2'b00;
    localparam logic [1:0] B_QUATRO   = 2'b01;
    localparam logic [1:0] B_IMM      = 2'b10;
    localparam logic [1:0] B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] MR_ALUOUT = 2'b00;
    localparam logic [1:0] MR_MDR    = 2'b01;

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle control unit (master) and the datapath (slave).
interface controle_multiciclo_if;
    import controle_pkg::*;

    logic [OP_W-1:0] OPcode;
    logic [5:0]      funct;
    logic            zero;
    logic            EscreveMem;
    logic            EscrevePC;
    logic            EscrevePCCond;
    logic            BranchNe;
    logic [1:0]      OrigPC;
    logic            RegDst;
    logic            EscreveReg;
    logic [1:0]      MemparaReg;
    logic            IouD;
    logic            EscreveIR;
    logic            EscreveMDR;
    logic            EscreveAluOut;
    logic            OrigAALU;
    logic [1:0]      OrigBALU;
    logic [2:0]      OpALU;
    logic [5:0]      State;
    logic            Trap;

    modport master (
        input  OPcode, funct, zero,
        output EscreveMem, EscrevePC, EscrevePCCond, BranchNe, OrigPC, RegDst,
               EscreveReg, MemparaReg, IouD, EscreveIR, EscreveMDR, EscreveAluOut,
               OrigAALU, OrigBALU, OpALU, State, Trap
    );

    modport slave (
        output OPcode, funct, zero,
        input  EscreveMem, EscrevePC, EscrevePCCond, BranchNe, OrigPC, RegDst,
               EscreveReg, MemparaReg, IouD, EscreveIR, EscreveMDR, EscreveAluOut,
               OrigAALU, OrigBALU, OpALU, State, Trap
    );

endinterface

// File: rtl/controle_multiciclo.sv
// Moore multicycle control unit: sequences fetch/decode/execute/writeback and drives every datapath control line.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned LARGURA_ESTADO = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [5:0]                OPcode,
    input  logic [5:0]                funct,
    input  logic                      zero,
    output logic                      EscreveMem,
    output logic                      EscrevePC,
    output logic                      EscrevePCCond,
    output logic                      BranchNe,
    output logic [1:0]                OrigPC,
    output logic                      RegDst,
    output logic                      EscreveReg,
    output logic [1:0]                MemparaReg,
    output logic                      IouD,
    output logic                      EscreveIR,
    output logic                      EscreveMDR,
    output logic                      EscreveAluOut,
    output logic                      OrigAALU,
    output logic [1:0]                OrigBALU,
    output logic [2:0]                OpALU,
    output logic [LARGURA_ESTADO-1:0] State,
    output logic                      Trap
);

    estado_t estado_q, estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado_q <= RESET;
        else        estado_q <= estado_d;
    end

    assign State = LARGURA_ESTADO'(estado_q);

    always_comb begin
        estado_d      = RESET;
        EscreveMem    = 1'b0;
        EscrevePC     = 1'b0;
        EscrevePCCond = 1'b0;
        BranchNe      = 1'b0;
        OrigPC        = PC_ALU;
        RegDst        = 1'b0;
        EscreveReg    = 1'b0;
        MemparaReg    = MR_ALUOUT;
        IouD          = 1'b0;
        EscreveIR     = 1'b0;
        EscreveMDR    = 1'b0;
        EscreveAluOut = 1'b0;
        OrigAALU      = 1'b0;
        OrigBALU      = B_REG;
        OpALU         = ALU_ADD;
        Trap          = 1'b0;

        case (estado_q)
            RESET: estado_d = BUSCA;
            BUSCA: begin
                OrigBALU = B_QUATRO;
                estado_d = BUSCA_ESPERA;
            end
            BUSCA_ESPERA: begin
                OrigBALU = B_QUATRO;
                estado_d = BUSCA_IR;
            end
            BUSCA_IR: begin
                OrigBALU  = B_QUATRO;
                EscreveIR = 1'b1;
                EscrevePC = 1'b1;
                estado_d  = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively here for BEQ/BNE
                OrigBALU      = B_IMM_SHL2;
                EscreveAluOut = 1'b1;
                case (OPcode)
                    OP_R:         estado_d = R_EXEC;
                    OP_LW, OP_SW: estado_d = MEM_ENDERECO;
                    OP_BEQ:       estado_d = BEQ;
                    OP_BNE:       estado_d = BNE;
                    OP_J:         estado_d = JUMP;
                    OP_ADDI:      estado_d = ADDI_EXEC;
                    default:      estado_d = INVALIDO;
                endcase
            end
            MEM_ENDERECO: begin
                OrigAALU      = 1'b1;
                OrigBALU      = B_IMM;
                EscreveAluOut = 1'b1;
                estado_d      = (OPcode == OP_LW) ? LW_LEITURA : SW_ESCRITA;
            end
            LW_LEITURA: begin
                IouD     = 1'b1;
                estado_d = LW_ESPERA;
            end
            LW_ESPERA: begin
                IouD     = 1'b1;
                estado_d = LW_MDR;
            end
            LW_MDR: begin
                IouD       = 1'b1;
                EscreveMDR = 1'b1;
                estado_d   = LW_ESCRITA;
            end
            LW_ESCRITA: begin
                MemparaReg = MR_MDR;
                EscreveReg = 1'b1;
                estado_d   = BUSCA;
            end
            SW_ESCRITA: begin
                IouD       = 1'b1;
                EscreveMem = 1'b1;
                estado_d   = BUSCA;
            end
            R_EXEC: begin
                OrigAALU      = 1'b1;
                OpALU         = ALU_FUNCT;
                EscreveAluOut = 1'b1;
                estado_d      = R_ESCRITA;
            end
            R_ESCRITA: begin
                RegDst     = 1'b1;
                EscreveReg = 1'b1;
                estado_d   = BUSCA;
            end
            ADDI_EXEC: begin
                OrigAALU      = 1'b1;
                OrigBALU      = B_IMM;
                EscreveAluOut = 1'b1;
                estado_d      = ADDI_ESCRITA;
            end
            ADDI_ESCRITA: begin
                EscreveReg = 1'b1;
                estado_d   = BUSCA;
            end
            BEQ, BNE: begin
                OrigAALU      = 1'b1;
                OpALU         = ALU_SUB;
                EscrevePCCond = 1'b1;
                BranchNe      = (estado_q == BNE);
                OrigPC        = PC_ALUOUT;
                estado_d      = BUSCA;
            end
            JUMP: begin
                EscrevePC = 1'b1;
                OrigPC    = PC_JUMP;
                estado_d  = BUSCA;
            end
            INVALIDO: begin
                Trap     = 1'b1;
                estado_d = INVALIDO;
            end
            default: estado_d = RESET;
        endcase
    end

    // zero and funct are consumed downstream; only their validity is checked here
    a_zero_known: assert property (@(posedge clock) disable iff (!reset)
        EscrevePCCond |-> !$isunknown(zero));
    a_funct_known: assert property (@(posedge clock) disable iff (!reset)
        (estado_q == R_EXEC) |-> !$isunknown(funct));

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench: instruction-level path model feeds expected state/outputs; a negedge monitor compares.
module tb_controle_multiciclo;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    controle_multiciclo_if bus();

    controle_multiciclo #(.LARGURA_ESTADO(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .OPcode        (bus.OPcode),
        .funct         (bus.funct),
        .zero          (bus.zero),
        .EscreveMem    (bus.EscreveMem),
        .EscrevePC     (bus.EscrevePC),
        .EscrevePCCond (bus.EscrevePCCond),
        .BranchNe      (bus.BranchNe),
        .OrigPC        (bus.OrigPC),
        .RegDst        (bus.RegDst),
        .EscreveReg    (bus.EscreveReg),
        .MemparaReg    (bus.MemparaReg),
        .IouD          (bus.IouD),
        .EscreveIR     (bus.EscreveIR),
        .EscreveMDR    (bus.EscreveMDR),
        .EscreveAluOut (bus.EscreveAluOut),
        .OrigAALU      (bus.OrigAALU),
        .OrigBALU      (bus.OrigBALU),
        .OpALU         (bus.OpALU),
        .State         (bus.State),
        .Trap          (bus.Trap)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [5:0]  exp_q[$];
    bit          mon_on = 1'b0;
    logic [20:0] act_outs;

    assign act_outs = {bus.EscreveMem, bus.EscrevePC, bus.EscrevePCCond, bus.BranchNe,
                       bus.OrigPC, bus.RegDst, bus.EscreveReg, bus.MemparaReg, bus.IouD,
                       bus.EscreveIR, bus.EscreveMDR, bus.EscreveAluOut, bus.OrigAALU,
                       bus.OrigBALU, bus.OpALU, bus.Trap};

    // Expected control lines per state code, taken straight from the state action table
    function automatic logic [20:0] outs_for(input logic [5:0] s);
        logic mem = 0, pc = 0, pcc = 0, bne = 0, rdst = 0, ereg = 0, iord = 0;
        logic eir = 0, emdr = 0, eao = 0, srca = 0, trap = 0;
        logic [1:0] opc = 0, m2r = 0, srcb = 0;
        logic [2:0] alu = 0;
        case (s)
            6'd1, 6'd2: srcb = 2'b01;
            6'd3:  begin srcb = 2'b01; eir = 1; pc = 1; end
            6'd4:  begin srcb = 2'b11; eao = 1; end
            6'd5:  begin srca = 1; srcb = 2'b10; eao = 1; end
            6'd6, 6'd7: iord = 1;
            6'd8:  begin iord = 1; emdr = 1; end
            6'd9:  begin m2r = 2'b01; ereg = 1; end
            6'd10: begin iord = 1; mem = 1; end
            6'd11: begin srca = 1; alu = 3'b010; eao = 1; end
            6'd12: begin rdst = 1; ereg = 1; end
            6'd13: begin srca = 1; srcb = 2'b10; eao = 1; end
            6'd14: ereg = 1;
            6'd15, 6'd16: begin srca = 1; alu = 3'b001; pcc = 1; opc = 2'b01; bne = (s == 6'd16); end
            6'd17: begin pc = 1; opc = 2'b10; end
            6'd18: trap = 1;
            default: ;
        endcase
        return {mem, pc, pcc, bne, opc, rdst, ereg, m2r, iord, eir, emdr, eao, srca, srcb, alu, trap};
    endfunction

    // Whole-instruction state trace: common fetch/decode prefix then the opcode's tail
    function automatic int push_path(input logic [5:0] op);
        int n = 0;
        for (int s = 1; s <= 4; s++) begin exp_q.push_back(6'(s)); n++; end
        case (op)
            6'h00: begin exp_q.push_back(6'd11); exp_q.push_back(6'd12); n += 2; end
            6'h23: begin
                for (int s = 5; s <= 9; s++) exp_q.push_back(6'(s));
                n += 5;
            end
            6'h2B: begin exp_q.push_back(6'd5); exp_q.push_back(6'd10); n += 2; end
            6'h04: begin exp_q.push_back(6'd15); n++; end
            6'h05: begin exp_q.push_back(6'd16); n++; end
            6'h02: begin exp_q.push_back(6'd17); n++; end
            6'h08: begin exp_q.push_back(6'd13); exp_q.push_back(6'd14); n += 2; end
            default: begin exp_q.push_back(6'd18); n++; end
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        logic [5:0] s;
        if (mon_on) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL underflow: got state %0d expected none at %0t", bus.State, $time);
            end else begin
                s = exp_q.pop_front();
                chk("state", 32'(bus.State), 32'(s));
                chk("outs", 32'(act_outs), 32'(outs_for(s)));
            end
        end
    end

    initial begin
        bus.zero = 1'b0;
        forever begin
            @(posedge clock);
            #2 bus.zero = 1'($urandom);
        end
    end

    task automatic run_instr(input logic [5:0] op);
        int n;
        n = push_path(op);
        bus.OPcode = op;
        bus.funct  = 6'($urandom);
        repeat (n) @(posedge clock);
        #1;
    endtask

    localparam logic [5:0] VALID_OPS [7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};

    initial begin
        bus.OPcode = 6'h00;
        bus.funct  = 6'h00;
        reset      = 1'b0;

        repeat (3) begin
            @(negedge clock);
            chk("rst_state", 32'(bus.State), 32'd0);
            chk("rst_outs", 32'(act_outs), 32'd0);
        end
        reset = 1'b1;
        #1 mon_on = 1'b1;

        run_instr(6'h23);
        run_instr(6'h2B);
        run_instr(6'h00);
        run_instr(6'h08);
        run_instr(6'h05);
        run_instr(6'h02);
        run_instr(6'h04);
        for (int i = 0; i < 40; i++)
            run_instr(VALID_OPS[$urandom_range(0, 6)]);

        run_instr(6'h3F);
        repeat (20) exp_q.push_back(6'd18);
        repeat (20) @(posedge clock);
        @(negedge clock);
        #1 mon_on = 1'b0;
        chk("drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a store must kill the write immediately
        @(negedge clock) reset = 1'b0;
        #1 chk("rst2_state", 32'(bus.State), 32'd0);
        @(negedge clock) reset = 1'b1;
        bus.OPcode = 6'h2B;
        repeat (6) @(posedge clock);
        #2;
        chk("sw_state", 32'(bus.State), 32'd10);
        chk("sw_mem", 32'(bus.EscreveMem), 32'd1);
        chk("sw_iord", 32'(bus.IouD), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_mem", 32'(bus.EscreveMem), 32'd0);
        chk("abort_state", 32'(bus.State), 32'd0);
        chk("abort_outs", 32'(act_outs), 32'd0);
        @(negedge clock) reset = 1'b1;
        @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Moore-style multicycle control unit for the MIPS datapath. Sits directly upstream of the datapath top level and drives every datapath control line from the IR opcode and the ALU zero flag. Sequences each instruction through fetch, memory wait, decode, execute and writeback.
Supports R-type, LW, SW, BEQ, BNE, J and ADDI. Any other opcode parks the unit in a trap state.

Parameters:
LARGURA_ESTADO, 6, width of the State debug output

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
OPcode  in  6  IR[31:26]
funct  in  6  IR[5:0]; carried through for visibility, does not affect sequencing
zero  in  1  ALU zero flag
EscreveMem  out  1  memory write enable
EscrevePC  out  1  unconditional PC load
EscrevePCCond  out  1  conditional PC load (branch)
BranchNe  out  1  1 = branch taken when zero==0
OrigPC  out  2  PC source: 00 ALU, 01 AluOut, 10 jump target
RegDst  out  1  0 = rt, 1 = rd
EscreveReg  out  1  register-bank write enable
MemparaReg  out  2  00 AluOut, 01 MDR
IouD  out  1  0 = PC, 1 = AluOut as memory address
EscreveIR  out  1  IR load
EscreveMDR  out  1  MDR load
EscreveAluOut  out  1  AluOut load
OrigAALU  out  1  0 = PC, 1 = A
OrigBALU  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
OpALU  out  3  000 add, 001 sub, 010 decode by funct
State  out  6  current state code
Trap  out  1  high while in INVALIDO

Behaviour:
- Reset (reset==0, asynchronous):
  - state goes to RESET (0).
  - All outputs are 0; Trap is 0.
  - After reset is released, the first rising edge moves to BUSCA.
- Outputs are a pure function of the state (Moore). Next state is a function of the state and OPcode. There are no registered outputs besides the state itself.
- Any write enable not listed for a state is 0. Mux selects not listed are 0.
- State codes and actions:
  - 0 RESET: all outputs 0 -> BUSCA.
  - 1 BUSCA: IouD=0, OrigAALU=0, OrigBALU=01, OpALU=000 -> BUSCA_ESPERA.
  - 2 BUSCA_ESPERA: same selects as BUSCA. The memory read latency is 1 cycle -> BUSCA_IR.
  - 3 BUSCA_IR: same selects, plus EscreveIR=1, EscrevePC=1, OrigPC=00 (PC <= PC+4) -> DECODE.
  - 4 DECODE: OrigAALU=0, OrigBALU=11, OpALU=000, EscreveAluOut=1 (latches the branch target). Dispatch by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ENDERECO
    - 0x04 -> BEQ
    - 0x05 -> BNE
    - 0x02 -> JUMP
    - 0x08 -> ADDI_EXEC
    - anything else -> INVALIDO
  - 5 MEM_ENDERECO: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1. Goes to LW_LEITURA if opcode is 0x23, else SW_ESCRITA.
  - 6 LW_LEITURA: IouD=1 -> LW_ESPERA.
  - 7 LW_ESPERA: IouD=1 -> LW_MDR.
  - 8 LW_MDR: IouD=1, EscreveMDR=1 -> LW_ESCRITA.
  - 9 LW_ESCRITA: RegDst=0, MemparaReg=01, EscreveReg=1 -> BUSCA.
  - 10 SW_ESCRITA: IouD=1, EscreveMem=1 for exactly 1 cycle -> BUSCA.
  - 11 R_EXEC: OrigAALU=1, OrigBALU=00, OpALU=010, EscreveAluOut=1 -> R_ESCRITA.
  - 12 R_ESCRITA: RegDst=1, MemparaReg=00, EscreveReg=1 -> BUSCA.
  - 13 ADDI_EXEC: OrigAALU=1, OrigBALU=10, OpALU=000, EscreveAluOut=1 -> ADDI_ESCRITA.
  - 14 ADDI_ESCRITA: RegDst=0, MemparaReg=00, EscreveReg=1 -> BUSCA.
  - 15 BEQ: OrigAALU=1, OrigBALU=00, OpALU=001, EscrevePCCond=1, BranchNe=0, OrigPC=01 -> BUSCA.
  - 16 BNE: same as BEQ but BranchNe=1 -> BUSCA.
  - 17 JUMP: EscrevePC=1, OrigPC=10 -> BUSCA.
  - 18 INVALIDO: Trap=1, all enables 0. Stays here until reset.
- Unused state codes fall to RESET on the next edge (safe default).
- Instruction cycle counts: LW 9, SW 6, R 6, ADDI 6, BEQ/BNE 5, J 5.
- OPcode is sampled only in DECODE and MEM_ENDERECO. The IR is stable during both, because EscreveIR is asserted only in BUSCA_IR.
- Reset asserted mid-instruction (e.g. in SW_ESCRITA) drops EscreveMem and all other outputs to 0 asynchronously, with no completing write.
- The branch decision is made outside this block: PC load = EscrevePC | (EscrevePCCond & (zero ^ BranchNe)). The zero input is exposed for assertions only.

Decomposition:
- Shared package controle_pkg holds:
  - the typedef enum for estado_t (6-bit, the codes above);
  - opcode constants OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI;
  - localparams for the OpALU, OrigBALU and OrigPC encodings.
- No sub-module: one state register plus one combinational output/next-state block.

Test Plan:
- Hold reset low 3 cycles, then release -> all outputs 0 while low, State=0. One edge later State=1 with OrigBALU=01, IouD=0.
- Drive OPcode=0x23 (LW) from BUSCA_IR onward -> State sequence 1,2,3,4,5,6,7,8,9,1. EscreveMDR high only in state 8; EscreveReg with MemparaReg=01 only in state 9.
- OPcode=0x2B (SW) -> sequence 1,2,3,4,5,10,1. EscreveMem high exactly 1 cycle, with IouD=1.
- OPcode=0x00, then 0x08 -> R path 4,11,12 with OpALU=010 and RegDst=1. ADDI path 4,13,14 with RegDst=0 and OrigBALU=10.
- OPcode=0x05 -> state 16 with EscrevePCCond=1, BranchNe=1, OpALU=001, OrigPC=01. OPcode=0x02 -> state 17 with EscrevePC=1, OrigPC=10.
- OPcode=0x3F -> State=18, Trap=1, held for 20 cycles. Pulsing reset low while in state 10 drops EscreveMem to 0 immediately, before any clock edge.
